// File: rtl/balance_pkg.sv
// Shared types, constants and saturation helpers for the balance controller.
// Optional build macro RATE_LIMIT_EN (used by balance_cntrl_pipe).
package balance_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SOFT = 2'd1,
    RUN  = 2'd2
  } bal_state_e;

  // Steering pot window and centre
  localparam int STEER_MIN = 'h200;
  localparam int STEER_MAX = 'hE00;
  localparam int STEER_MID = 'h7FF;
  localparam int STEER_GAIN = 3;

  // Shift amounts
  localparam int D_SHIFT      = 6;
  localparam int I_SHIFT_FAST = 1;
  localparam int I_SHIFT_SLOW = 6;
  localparam int SS_SHIFT     = 8;
  localparam int STEER_SHIFT  = 4;

  localparam int PSAT_W    = 10;
  localparam int TERM_W    = 12;
  localparam int INTEG_W   = 18;
  localparam int NUM_LANES = 2;   // lane 0 = left, lane 1 = right
  localparam int RATE_STEP = 64;

  // S1 -> S2 payload
  typedef struct packed {
    logic signed [PSAT_W-1:0] p;
    logic signed [TERM_W-1:0] i;
    logic signed [TERM_W-1:0] d;
  } pid_terms_t;

  function automatic logic signed [31:0] clampv(input logic signed [31:0] v,
                                                input logic signed [31:0] lo,
                                                input logic signed [31:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [9:0] sat10(input logic signed [31:0] v);
    if (v > 32'sd511)  return 10'sh1ff;
    if (v < -32'sd512) return 10'sh200;
    return v[9:0];
  endfunction

  function automatic logic signed [11:0] sat12(input logic signed [31:0] v);
    if (v > 32'sd2047)  return 12'sh7ff;
    if (v < -32'sd2048) return 12'sh800;
    return v[11:0];
  endfunction

  function automatic logic signed [17:0] sat18(input logic signed [31:0] v);
    if (v > 32'sd131071)  return 18'sh1ffff;
    if (v < -32'sd131072) return 18'sh20000;
    return v[17:0];
  endfunction

endpackage

// File: rtl/balance_pid_core.sv
// S1/S2 of the balance pipeline: saturating integrator, P/I/D terms and the
// saturated PID sum. pid is combinational from the S1 registers.
module balance_pid_core
  import balance_pkg::*;
#(
  parameter int fast_sim = 1,
  parameter int PTCH_W   = 16,
  parameter int P_COEF   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     smp_vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic signed [PTCH_W-1:0] ptch_rt,
  output logic signed [TERM_W-1:0] pid
);

  localparam int I_SHIFT = (fast_sim != 0) ? I_SHIFT_FAST : I_SHIFT_SLOW;

  logic signed [INTEG_W-1:0] integ;
  logic signed [INTEG_W-1:0] integ_nxt;
  pid_terms_t                terms_q, terms_d;
  logic signed [31:0]        ptch_x, rt_x, integ_x, ps_x, sum_x;

  // S1 term formation; I uses the integrator before this sample lands
  always_comb begin
    ptch_x    = 32'(ptch);
    rt_x      = 32'(ptch_rt);
    integ_x   = 32'(integ);
    terms_d.p = sat10(ptch_x);
    terms_d.d = sat12(-(rt_x >>> D_SHIFT));
    terms_d.i = sat12(integ_x >>> I_SHIFT);
    ps_x      = 32'(terms_d.p);
    integ_nxt = sat18(integ_x + ps_x);
  end

  // S1 registers and integrator; clear wins over accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ   <= '0;
      terms_q <= '0;
    end else begin
      if (clr)          integ <= '0;
      else if (smp_vld) integ <= integ_nxt;
      if (smp_vld)      terms_q <= terms_d;
    end
  end

  // S2 sum
  always_comb begin
    sum_x = P_COEF * 32'(terms_q.p) + 32'(terms_q.i) + 32'(terms_q.d);
    pid   = sat12(sum_x);
  end

endmodule

// File: rtl/balance_cntrl_pipe.sv
// Balance controller: 3-stage PID pipeline, soft-start FSM, steering mix,
// speed clipping and too_fast flag. Optional macro RATE_LIMIT_EN limits each
// output step to +/-RATE_STEP.
module balance_cntrl_pipe
  import balance_pkg::*;
#(
  parameter int fast_sim = 1,
  parameter int PTCH_W   = 16,
  parameter int SPD_W    = 12,
  parameter int P_COEF   = 5,
  parameter int TOO_FAST = 1536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic signed [PTCH_W-1:0] ptch_rt,
  input  logic                     pwr_up,
  input  logic                     rider_off,
  input  logic                     en_steer,
  input  logic [11:0]              steer_pot,
  output logic signed [SPD_W-1:0]  lft_spd,
  output logic signed [SPD_W-1:0]  rght_spd,
  output logic                     too_fast,
  output logic                     out_vld
);

  localparam int CNT_W  = (fast_sim != 0) ? 9 : 27;
  localparam int STAGES = 2;
  localparam int SPD_MAX = (1 << (SPD_W - 1)) - 1;
  localparam int SPD_MIN = -(1 << (SPD_W - 1));

  bal_state_e                          state;
  logic [CNT_W-1:0]                    ss_cnt;
  logic [8:0]                          ss_tmr;
  logic [STAGES:0]                     vld_pipe;
  logic                                accept;
  logic signed [TERM_W-1:0]            pid, pid_ss;
  logic signed [31:0]                  pid_x, ss_x, pss_x;
  logic signed [31:0]                  pot_x, pot_c, steer_x, pss_ext;
  logic signed [31:0]                  lane_raw, lane_clip;
`ifdef RATE_LIMIT_EN
  logic signed [31:0]                  lane_prev;
`endif
  logic [NUM_LANES-1:0][SPD_W-1:0]     spd_q, spd_nxt;
  logic [NUM_LANES-1:0]                tf_nxt;

  assign ss_tmr = (state == RUN) ? 9'd256 : {1'b0, ss_cnt[CNT_W-1 -: 8]};
  assign accept = vld & pwr_up & (state != OFF);

  // Power FSM and soft-start counter; pwr_up low drops to OFF from anywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      ss_cnt <= '0;
    end else if (!pwr_up) begin
      state  <= OFF;
      ss_cnt <= '0;
    end else begin
      case (state)
        OFF:  state <= SOFT;
        SOFT: if (ss_cnt[CNT_W-1 -: 8] == 8'hFF) state <= RUN;
              else ss_cnt <= ss_cnt + 1'b1;
        RUN:  state <= RUN;
        default: state <= OFF;
      endcase
    end
  end

  balance_pid_core #(
    .fast_sim(fast_sim),
    .PTCH_W  (PTCH_W),
    .P_COEF  (P_COEF)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    ((state == OFF) | rider_off),
    .smp_vld(accept),
    .ptch   (ptch),
    .ptch_rt(ptch_rt),
    .pid    (pid)
  );

  // Valid shift register; a power drop flushes it and emits one strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_pipe <= '0;
    else if (!pwr_up) vld_pipe <= {(state != OFF), {STAGES{1'b0}}};
    else              vld_pipe <= {vld_pipe[STAGES-1:0], accept};
  end

  // S2 soft-start scaling
  always_comb begin
    pid_x = 32'(pid);
    ss_x  = {23'd0, ss_tmr};
    pss_x = (pid_x * ss_x) >>> SS_SHIFT;
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pid_ss <= '0;
    else if (vld_pipe[0]) pid_ss <= sat12(pss_x);
  end

  // S3 steering mix, clip, optional rate limit, overspeed per lane
  always_comb begin
    spd_nxt   = '0;
    tf_nxt    = '0;
    lane_raw  = '0;
    lane_clip = '0;
    pot_x     = {20'd0, steer_pot};
    pot_c     = clampv(pot_x, STEER_MIN, STEER_MAX);
    steer_x   = ((pot_c - STEER_MID) * STEER_GAIN) >>> STEER_SHIFT;
    pss_ext   = 32'(pid_ss);
`ifdef RATE_LIMIT_EN
    lane_prev = '0;
`endif
    for (int l = 0; l < NUM_LANES; l++) begin
      if (!en_steer)   lane_raw = pss_ext;
      else if (l == 0) lane_raw = pss_ext + steer_x;
      else             lane_raw = pss_ext - steer_x;
      lane_clip = clampv(lane_raw, SPD_MIN, SPD_MAX);
`ifdef RATE_LIMIT_EN
      lane_prev = 32'(signed'(spd_q[l]));
      lane_clip = clampv(lane_clip, lane_prev - RATE_STEP, lane_prev + RATE_STEP);
`endif
      spd_nxt[l] = lane_clip[SPD_W-1:0];
      tf_nxt[l]  = (lane_clip > TOO_FAST);
    end
  end

  // Output registers; forced to zero while powered down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q    <= '0;
      too_fast <= 1'b0;
    end else if (!pwr_up) begin
      spd_q    <= '0;
      too_fast <= 1'b0;
    end else if (vld_pipe[1]) begin
      spd_q    <= spd_nxt;
      too_fast <= |tf_nxt;
    end
  end

  assign lft_spd  = signed'(spd_q[0]);
  assign rght_spd = signed'(spd_q[1]);
  assign out_vld  = vld_pipe[STAGES];

endmodule

// File: tb/tb_balance_cntrl_pipe.sv
// Directed + randomized bench for balance_cntrl_pipe against an arithmetic model.
module tb_balance_cntrl_pipe;

  logic               clk = 1'b0;
  logic               rst_n, vld, pwr_up, rider_off, en_steer;
  logic signed [15:0] ptch, ptch_rt;
  logic [11:0]        steer_pot;
  logic signed [11:0] lft_spd, rght_spd;
  logic               too_fast, out_vld;

  int ncmp = 0;
  int nfail = 0;

  typedef struct { int l; int r; int tf; } exp_t;
  exp_t exp_q[$];
  int   m_integ = 0;
  int   m_prev_l = 0;
  int   m_prev_r = 0;

  balance_cntrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
    .pwr_up(pwr_up), .rider_off(rider_off), .en_steer(en_steer),
    .steer_pot(steer_pot), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .too_fast(too_fast), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: one sample in RUN (no soft-start scaling), fast_sim integrator shift
  function automatic void model(input int p, input int rt, input bit roff);
    int ps, d, i, pid, st, l, r;
    exp_t e;
    ps = sat(p, -512, 511);
    d  = sat(-(rt >>> 6), -2048, 2047);
    i  = sat(m_integ >>> 1, -2048, 2047);
    m_integ = roff ? 0 : sat(m_integ + ps, -131072, 131071);
    pid = sat(5 * ps + i + d, -2048, 2047);
    st = en_steer ? (((sat(int'(steer_pot), 512, 3584) - 2047) * 3) >>> 4) : 0;
    l = sat(pid + st, -2048, 2047);
    r = sat(pid - st, -2048, 2047);
`ifdef RATE_LIMIT_EN
    l = sat(l, m_prev_l - 64, m_prev_l + 64);
    r = sat(r, m_prev_r - 64, m_prev_r + 64);
`endif
    m_prev_l = l;
    m_prev_r = r;
    e.l = l; e.r = r; e.tf = (l > 1536 || r > 1536) ? 1 : 0;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input int rt, input bit roff);
    ptch = p[15:0]; ptch_rt = rt[15:0]; rider_off = roff; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0; rider_off = 1'b0;
  endtask

  // Pop n expected results as out_vld strobes arrive, bounded wait
  task automatic collect(input int n);
    int got = 0;
    exp_t e;
    for (int k = 0; k < 12 && got < n; k++) begin
      if (out_vld) begin
        e = exp_q.pop_front();
        check("lft_spd", int'(lft_spd), e.l);
        check("rght_spd", int'(rght_spd), e.r);
        check("too_fast", int'(too_fast), e.tf);
        got++;
      end
      @(negedge clk);
    end
    if (got < n) begin
      check("out_vld_timeout", got, n);
      exp_q.delete();
    end
  endtask

  task automatic send(input int p, input int rt, input bit roff);
    model(p, rt, roff);
    drive(p, rt, roff);
    collect(1);
  endtask

  task automatic burst(input int n);
    int p, rt;
    for (int i = 0; i < n; i++) begin
      p  = int'($urandom_range(0, 1400)) - 700;
      rt = int'($urandom_range(0, 65535)) - 32768;
      model(p, rt, 1'b0);
      drive(p, rt, 1'b0);
    end
    collect(n);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; vld = 1'b0; pwr_up = 1'b0; rider_off = 1'b0;
    en_steer = 1'b0; steer_pot = 12'h7FF; ptch = '0; ptch_rt = '0;
    repeat (3) @(negedge clk);
    check("rst_lft", int'(lft_spd), 0);
    check("rst_rght", int'(rght_spd), 0);
    check("rst_too_fast", int'(too_fast), 0);
    check("rst_out_vld", int'(out_vld), 0);

    // Powered off: samples are ignored
    rst_n = 1'b1;
    @(negedge clk);
    seen = 0;
    for (int k = 0; k < 3; k++) drive(100, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin seen += int'(out_vld); @(negedge clk); end
    check("off_no_vld", seen, 0);
    check("off_lft", int'(lft_spd), 0);

    // Soft start into RUN
    pwr_up = 1'b1;
    repeat (530) @(negedge clk);
    send(16, 0, 1'b0);
    send(16, 0, 1'b0);
    send('h1FF, 0, 1'b0);

    // Clear integrator, then full-right steering with zero PID
    send(0, 0, 1'b1);
    en_steer = 1'b1; steer_pot = 12'hFFF;
    send(0, 0, 1'b0);
    en_steer = 1'b0; steer_pot = 12'h7FF;

    // Random back-to-back bursts, steering on/off
    for (int b = 0; b < 25; b++) begin
      en_steer  = 1'($urandom_range(0, 1));
      steer_pot = 12'($urandom_range(0, 4095));
      burst(int'($urandom_range(1, 3)));
    end
    en_steer = 1'b0;

    // Positive saturation, rider_off clear, then P term only
    for (int k = 0; k < 260; k++) send(511, 0, 1'b0);
    send(0, 0, 1'b1);
    send(16, 0, 1'b0);

    // Negative saturation must hold without wrap
    for (int k = 0; k < 520; k++) send(-600, 0, 1'b0);
    for (int k = 0; k < 3; k++) send(1, 0, 1'b0);

    // Power drop with a sample in flight
    send('h1FF, 0, 1'b0);
    ptch = 16'sh01FF; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0; pwr_up = 1'b0;
    @(negedge clk);
    check("drop_out_vld", int'(out_vld), 1);
    check("drop_lft", int'(lft_spd), 0);
    check("drop_rght", int'(rght_spd), 0);
    check("drop_too_fast", int'(too_fast), 0);
    @(negedge clk);
    seen = 0;
    for (int k = 0; k < 6; k++) begin seen += int'(out_vld); @(negedge clk); end
    drive(100, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin seen += int'(out_vld); @(negedge clk); end
    check("drop_discard", seen, 0);
    m_integ = 0; m_prev_l = 0; m_prev_r = 0;

    // Repower: soft-start counter restarted, so a sample early in SOFT is scaled down
    pwr_up = 1'b1;
    repeat (4) @(negedge clk);
    drive(100, 0, 1'b0);
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      if (out_vld) begin
        seen = 1;
        check("soft_scaled", (lft_spd >= 12'sd1 && lft_spd <= 12'sd20) ? 1 : 0, 1);
      end else @(negedge clk);
    end
    check("soft_out_vld", seen, 1);

    // Clean restart, then a full-scale step (ramps when rate limited)
    pwr_up = 1'b0;
    repeat (3) @(negedge clk);
    m_integ = 0; m_prev_l = 0; m_prev_r = 0;
    pwr_up = 1'b1;
    repeat (530) @(negedge clk);
    for (int k = 0; k < 5; k++) send('h1FF, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
